// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: during horizontal blanking, copies one 1bpp sprite row from a byte-wide
// ROM into a local line buffer. During the active line it serves scaled, positioned and
// optionally mirrored pixels from that buffer, with one cycle of latency.
module sprite_line_fetcher #(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned ADDR_W     = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_start_i,
  input  logic [COORD_W-1:0] next_y_i,
  input  logic [COORD_W-1:0] hpos_i,
  input  logic [COORD_W-1:0] spr_x_i,
  input  logic [COORD_W-1:0] spr_y_i,
  input  logic               flip_x_i,
  input  logic               flip_y_i,
  output logic [ADDR_W-1:0]  rom_addr_o,
  input  logic [7:0]         rom_data_i,
  output logic               pixel_o,
  output logic               fetch_busy_o
);

  localparam int unsigned Bytes = SPR_W / 8;
  localparam int unsigned BW    = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned IW    = $clog2(SPR_W);
  localparam int unsigned DW    = COORD_W + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              busy_q, busy_d;
  logic              row_valid_q, row_valid_d;
  logic              flip_x_q, flip_x_d;
  logic              cap_en_q, cap_en_d;
  logic [BW-1:0]     cap_idx_q, cap_idx_d;
  logic              pixel_q, pixel_d;
  logic [SPR_W-1:0]  buf_q;

  logic [DW-1:0]     dy, row, row_sel;
  logic              hit;
  logic [ADDR_W-1:0] base_addr;

  // Row selection for the upcoming scanline; only consumed on line_start.
  always_comb begin
    dy        = {1'b0, next_y_i} - {1'b0, spr_y_i};
    row       = dy >> SCALE_LOG2;
    hit       = ~dy[DW-1] && (row < DW'(SPR_H));
    row_sel   = flip_y_i ? (DW'(SPR_H - 1) - row) : row;
    base_addr = ADDR_W'(32'(row_sel) * Bytes);
  end

  // Fetch sequencer: a new line_start always wins and restarts (or cancels) the fetch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rom_addr_d  = rom_addr_q;
    busy_d      = busy_q;
    row_valid_d = row_valid_q;
    flip_x_d    = flip_x_q;
    cap_en_d    = 1'b0;
    cap_idx_d   = idx_q;

    if (line_start_i) begin
      row_valid_d = 1'b0;
      flip_x_d    = flip_x_i;
      if (hit) begin
        state_d    = StFetch;
        idx_d      = '0;
        rom_addr_d = base_addr;
        busy_d     = 1'b1;
      end else begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          // The byte addressed this cycle arrives next cycle; remember where it goes.
          cap_en_d  = 1'b1;
          cap_idx_d = idx_q;
          if (idx_q == BW'(Bytes - 1)) begin
            state_d = StDrain;
          end else begin
            idx_d      = idx_q + BW'(1);
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
        end
        StDrain: begin
          state_d     = StIdle;
          row_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  logic [DW-1:0] dx, col;
  logic [IW-1:0] col_idx, col_sel;
  logic          col_in;

  // Pixel lookup for the current beam column; masked while the buffer is being refilled.
  always_comb begin
    dx      = {1'b0, hpos_i} - {1'b0, spr_x_i};
    col     = dx >> SCALE_LOG2;
    col_in  = ~dx[DW-1] && (col < DW'(SPR_W));
    col_idx = col[IW-1:0];
    col_sel = flip_x_q ? (IW'(SPR_W - 1) - col_idx) : col_idx;
    pixel_d = row_valid_q & ~busy_q & col_in & buf_q[col_sel];
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      row_valid_q <= 1'b0;
      flip_x_q    <= 1'b0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= '0;
      pixel_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rom_addr_q  <= rom_addr_d;
      busy_q      <= busy_d;
      row_valid_q <= row_valid_d;
      flip_x_q    <= flip_x_d;
      cap_en_q    <= cap_en_d;
      cap_idx_q   <= cap_idx_d;
      pixel_q     <= pixel_d;
    end
  end

  // Line buffer needs no reset: row_valid masks its contents until a full row has landed.
  always_ff @(posedge clk) begin
    if (cap_en_q) begin
      buf_q[{cap_idx_q, 3'b000} +: 8] <= rom_data_i;
    end
  end

  assign rom_addr_o   = rom_addr_q;
  assign fetch_busy_o = busy_q;
  assign pixel_o      = pixel_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench for sprite_line_fetcher with default parameters and a registered ROM model.
module tb_sprite_line_fetcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  logic       flip_x = 1'b0;
  logic       flip_y = 1'b0;
  logic [9:0] next_y = '0;
  logic [9:0] hpos = '0;
  logic [9:0] spr_x = 10'd100;
  logic [9:0] spr_y = 10'd50;
  logic [8:0] rom_addr;
  logic [7:0] rom_data;
  logic       pixel;
  logic       fetch_busy;

  logic [7:0] mem [512];
  int         n_tests = 0;
  int         n_fail = 0;
  int         last_addr = 0;
  logic       pq[$];
  int         aq[$];

  typedef struct {
    logic [9:0] hpos;
    logic       exp;
  } vec_t;
  vec_t tbl [15];

  sprite_line_fetcher dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_start_i (line_start),
    .next_y_i     (next_y),
    .hpos_i       (hpos),
    .spr_x_i      (spr_x),
    .spr_y_i      (spr_y),
    .flip_x_i     (flip_x),
    .flip_y_i     (flip_y),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .pixel_o      (pixel),
    .fetch_busy_o (fetch_busy)
  );

  always #5 clk = ~clk;

  // ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic e;
    @(posedge clk);
    #1;
    if (pq.size() > 0) begin
      e = pq.pop_front();
      chk("pixel", int'(pixel), int'(e));
    end
  endtask

  task automatic drive_px(input int h, input logic e);
    hpos = 10'(h);
    pq.push_back(e);
    step();
  endtask

  function automatic logic mdl(input int base, input int k, input bit fx);
    int c;
    logic [7:0] b;
    c = fx ? 63 - k : k;
    b = mem[9'(base + c / 8)];
    return b[3'(c % 8)];
  endfunction

  // Pulse line_start and follow the fetch; abort_at >= 0 returns in that fetch cycle.
  task automatic do_fetch(input int ny, input bit fy, input bit fx, input bit hit,
                          input int base, input int abort_at);
    hpos = '0;
    pq.push_back(1'b0);
    next_y = 10'(ny);
    flip_y = fy;
    flip_x = fx;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    flip_x = ~fx;  // must have been latched
    flip_y = ~fy;
    aq.delete();
    if (hit) begin
      for (int i = 0; i < 8; i++) aq.push_back(base + i);
      for (int c = 0; c < 9; c++) begin
        chk("busy_fetch", int'(fetch_busy), 1);
        if (c < 8) chk("rom_addr", int'(rom_addr), aq.pop_front());
        if (c == abort_at) return;
        hpos = 10'd110;
        pq.push_back(1'b0);
        step();
      end
      chk("busy_end", int'(fetch_busy), 0);
      last_addr = base + 7;
    end else begin
      for (int c = 0; c < 10; c++) begin
        chk("busy_nohit", int'(fetch_busy), 0);
        chk("addr_hold", int'(rom_addr), last_addr);
        hpos = 10'd110;
        pq.push_back(1'b0);
        step();
      end
    end
  endtask

  task automatic sweep(input int base, input bit fx, input bit valid);
    int dx;
    logic e;
    for (int h = 90; h < 236; h++) begin
      dx = h - 100;
      if (dx < 0 || dx / 2 >= 64 || !valid) e = 1'b0;
      else e = mdl(base, dx / 2, fx);
      drive_px(h, e);
    end
  endtask

  task automatic mem_default();
    for (int a = 0; a < 512; a++) mem[a] = 8'(a);
  endtask

  initial begin
    mem_default();
    tbl[0]  = '{10'd99,  1'b0};
    tbl[1]  = '{10'd100, 1'b0};
    tbl[2]  = '{10'd104, 1'b0};
    tbl[3]  = '{10'd106, 1'b1};
    tbl[4]  = '{10'd107, 1'b1};
    tbl[5]  = '{10'd116, 1'b1};
    tbl[6]  = '{10'd118, 1'b0};
    tbl[7]  = '{10'd122, 1'b1};
    tbl[8]  = '{10'd132, 1'b0};
    tbl[9]  = '{10'd134, 1'b1};
    tbl[10] = '{10'd212, 1'b1};
    tbl[11] = '{10'd218, 1'b1};
    tbl[12] = '{10'd220, 1'b0};
    tbl[13] = '{10'd226, 1'b0};
    tbl[14] = '{10'd228, 1'b0};

    // Reset values.
    #12;
    chk("rst_pixel", int'(pixel), 0);
    chk("rst_busy", int'(fetch_busy), 0);
    chk("rst_addr", int'(rom_addr), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Basic fetch of row 1, then table and full sweep.
    do_fetch(52, 1'b0, 1'b0, 1'b1, 8, -1);
    for (int i = 0; i < 15; i++) drive_px(int'(tbl[i].hpos), tbl[i].exp);
    sweep(8, 1'b0, 1'b1);

    // Rows just outside the sprite.
    do_fetch(49, 1'b0, 1'b0, 1'b0, 0, -1);
    sweep(0, 1'b0, 1'b0);
    do_fetch(178, 1'b0, 1'b0, 1'b0, 0, -1);
    sweep(0, 1'b0, 1'b0);
    // Last row inside the sprite.
    do_fetch(177, 1'b0, 1'b0, 1'b1, 504, -1);
    sweep(504, 1'b0, 1'b1);

    // Horizontal edges with an all-ones row.
    for (int i = 0; i < 8; i++) mem[80 + i] = 8'hff;
    do_fetch(70, 1'b0, 1'b0, 1'b1, 80, -1);
    drive_px(99, 1'b0);
    drive_px(100, 1'b1);
    drive_px(227, 1'b1);
    drive_px(228, 1'b0);
    mem_default();

    // Both mirrors.
    mem[504] = 8'h01;
    mem[510] = 8'h08;
    mem[511] = 8'h80;
    do_fetch(50, 1'b1, 1'b1, 1'b1, 504, -1);
    drive_px(100, 1'b1);
    drive_px(102, 1'b0);
    drive_px(124, 1'b1);
    drive_px(226, 1'b1);
    sweep(504, 1'b1, 1'b1);
    mem_default();

    // Abort at the 4th fetch cycle, restart on row 5.
    do_fetch(52, 1'b0, 1'b0, 1'b1, 8, 3);
    do_fetch(60, 1'b0, 1'b0, 1'b1, 40, -1);
    sweep(40, 1'b0, 1'b1);

    // Reset while a pixel is lit.
    drive_px(106, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_lit_pixel", int'(pixel), 0);
    chk("rst_lit_addr", int'(rom_addr), 0);
    step();
    rst_n = 1'b1;
    last_addr = 0;
    step();

    // Reset in the middle of a fetch.
    do_fetch(52, 1'b0, 1'b0, 1'b1, 8, 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(fetch_busy), 0);
    chk("rst_mid_pixel", int'(pixel), 0);
    chk("rst_mid_addr", int'(rom_addr), 0);
    step();
    step();
    rst_n = 1'b1;
    last_addr = 0;
    sweep(8, 1'b0, 1'b0);
    do_fetch(52, 1'b0, 1'b0, 1'b1, 8, -1);
    sweep(8, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
